// File: rtl/wave_envelope_adsr_if.sv
// Parameter, sample and status bundle between the DDS source, the ADSR stage and the DAC path.
// The master drives gate, the step/level controls and wave_in; the slave drives wave_out and envelope status.
interface wave_envelope_adsr_if #(
  parameter int WAVE_WIDTH = 16,
  parameter int ENV_WIDTH  = 16
);
  logic                         gate;
  logic        [ENV_WIDTH-1:0]  attack_step;
  logic        [ENV_WIDTH-1:0]  decay_step;
  logic        [ENV_WIDTH-1:0]  sustain_level;
  logic        [ENV_WIDTH-1:0]  release_step;
  logic signed [WAVE_WIDTH-1:0] wave_in;
  logic signed [WAVE_WIDTH-1:0] wave_out;
  logic        [ENV_WIDTH-1:0]  env_level;
  logic        [2:0]            env_state;
  logic                         active;

  modport master (
    output gate, attack_step, decay_step, sustain_level, release_step, wave_in,
    input  wave_out, env_level, env_state, active
  );

  modport slave (
    input  gate, attack_step, decay_step, sustain_level, release_step, wave_in,
    output wave_out, env_level, env_state, active
  );
endinterface

// File: rtl/wave_envelope_adsr.sv
// Gate-driven ADSR envelope applied to the DDS sample stream; wave_in -> wave_out latency is 2 clk.
// There is no backpressure: one sample is accepted and one is produced on every clk.
module wave_envelope_adsr #(
  parameter int WAVE_WIDTH = 16,
  parameter int ENV_WIDTH  = 16,
  parameter int RATE_DIV   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  wave_envelope_adsr_if.slave  bus
);
  localparam int PW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [PW-1:0]        PRESC_LAST = PW'(RATE_DIV - 1);
  localparam logic [ENV_WIDTH-1:0] ENV_MAX    = {ENV_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                              r_state, w_state_nxt;
  logic        [ENV_WIDTH-1:0]         r_env, w_env_nxt;
  logic        [PW-1:0]                r_presc;
  logic                                w_tick;
  logic        [ENV_WIDTH:0]           w_att_sum;
  logic        [ENV_WIDTH:0]           w_dec_lim;
  logic signed [WAVE_WIDTH+ENV_WIDTH:0] w_prod;
  logic signed [WAVE_WIDTH+ENV_WIDTH:0] r_prod;
  logic signed [WAVE_WIDTH-1:0]        r_wave;
  logic                                w_unused_prod;

  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_att_sum = {1'b0, r_env} + {1'b0, bus.attack_step};
  // env - decay_step <= sustain (underflow included) is env <= decay_step + sustain without wrap
  assign w_dec_lim = {1'b0, bus.decay_step} + {1'b0, bus.sustain_level};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_state <= S_IDLE;
      r_env   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
    end
  end

  // Gate edges win over level-reached transitions; a zero step acts without waiting for a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    case (r_state)
      S_IDLE: begin
        w_env_nxt = '0;
        if (bus.gate) w_state_nxt = S_ATTACK;
      end
      S_ATTACK: begin
        if (!bus.gate) begin
          w_state_nxt = S_RELEASE;
        end else if (bus.attack_step == '0 || (w_tick && w_att_sum >= {1'b0, ENV_MAX})) begin
          w_env_nxt   = ENV_MAX;
          w_state_nxt = S_DECAY;
        end else if (w_tick) begin
          w_env_nxt = w_att_sum[ENV_WIDTH-1:0];
        end
      end
      S_DECAY: begin
        if (!bus.gate) begin
          w_state_nxt = S_RELEASE;
        end else if (bus.decay_step == '0 || (w_tick && {1'b0, r_env} <= w_dec_lim)) begin
          w_env_nxt   = bus.sustain_level;
          w_state_nxt = S_SUSTAIN;
        end else if (w_tick) begin
          w_env_nxt = r_env - bus.decay_step;
        end
      end
      S_SUSTAIN: begin
        if (!bus.gate) w_state_nxt = S_RELEASE;
        else           w_env_nxt   = bus.sustain_level;
      end
      S_RELEASE: begin
        if (bus.gate) begin
          w_state_nxt = S_ATTACK;
        end else if (bus.release_step == '0 || (w_tick && r_env <= bus.release_step)) begin
          w_env_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          w_env_nxt = r_env - bus.release_step;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_env_nxt   = '0;
      end
    endcase
  end

  // Envelope is treated as an unsigned Q0.16 gain, so the output is the floor of x*env/2^16.
  assign w_prod = bus.wave_in * $signed({1'b0, r_env});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= '0;
      r_wave <= '0;
    end else begin
      r_prod <= w_prod;
      r_wave <= r_prod[ENV_WIDTH +: WAVE_WIDTH];
    end
  end

  assign w_unused_prod = ^{r_prod[ENV_WIDTH-1:0], r_prod[WAVE_WIDTH+ENV_WIDTH]};

  always_comb begin
    bus.wave_out  = r_wave;
    bus.env_level = r_env;
    bus.env_state = r_state;
    bus.active    = (r_state != S_IDLE);
  end
endmodule
